// File: rtl/uart_rx_if.sv
// Serial receive link between the board RX pin and the CPU peripheral block.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;

    modport master (output rx, input rx_data, rx_status, frame_err);
    modport slave  (input rx, output rx_data, rx_status, frame_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-flop input synchronizer, 8N1 framing.
// Optional even-parity (8E1) framing is enabled with `define UART_RX_PARITY_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge on rx_s
// S_START  | qualifying the start bit, sampled at its centre (8th tick)
// S_DATA   | sampling 8 data bits, LSB first, every 16th tick
// S_PARITY | sampling the even-parity bit (parity build only)
// S_STOP   | sampling the stop bit; publishes the byte or flags an error
// S_BREAK  | line held low after a framing error; wait for it to go high
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam int              DIV       = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int              DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0]      SAMP_MID  = 4'd7;
    localparam logic [3:0]      SAMP_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic [3:0]       samp_cnt_q, samp_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_status_q, rx_status_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif
    logic             tick;
    logic             rx_s;
    logic             frame_ok;

    // Free-running oversample divider and the two-stage line synchronizer.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        sync_d    = {sync_q[0], bus.rx};
        rx_s      = sync_q[1];
    end

    // Bit-level framing: next state, sample counters and output pulses.
    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_status_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
        frame_ok     = rx_s && !parity_err_q;
`else
        frame_ok     = rx_s;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    samp_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_MID) begin
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                        // A start bit that is high again at its centre was a glitch.
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d   = '0;
                        parity_err_d = ^{shift_q, rx_s};
                        state_d      = S_STOP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        if (frame_ok) begin
                            rx_data_d   = shift_q;
                            rx_status_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        // A low stop bit means the line may be held in break.
                        state_d = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves the line synchronizer idle-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            sync_q       <= 2'b11;
            samp_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_status_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            sync_q       <= sync_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_status_q  <= rx_status_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_status = rx_status_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver feeding the CPU's Peripheral block through the rx_data / rx_status inputs.
- Converts the asynchronous 8N1 serial line into a parallel byte with a one-cycle valid pulse.
- Uses a 16x oversampling tick generator, a 2-flop input synchronizer and a bit-level state machine.
- Sits between the board RX pin and the CPU top level.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high.
- rx_data  output  8  last correctly received byte, LSB first on the line.
- rx_status  output  1  one-clk pulse: rx_data just updated.
- frame_err  output  1  one-clk pulse: stop bit sampled low.

Behaviour:
- Reset (reset low, async): rx_data=8'h00, rx_status=0, frame_err=0, state=IDLE, synchronizer flops=1, all counters=0.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer division.
  - Counter counts 0..DIV-1; tick=1 for one clk when it wraps.
  - Free-running; never reset by line activity.
- Input path: rx passes through 2 flops, giving rx_s. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 on a clk -> START, with sample counter cleared.
- START:
  - Count ticks. At the 8th tick (bit centre), rx_s==0 -> DATA, with sample counter and bit index cleared.
  - Otherwise (glitch) -> IDLE, with no output activity.
- DATA:
  - Every 16th tick, shift rx_s into shift[7] (right shift, LSB first).
  - After bit index 7 is sampled -> STOP.
- STOP, on the 16th tick:
  - rx_s==1: rx_data<=shift, rx_status=1 for the next clk only -> IDLE.
  - rx_s==0: frame_err=1 for one clk, rx_data unchanged -> BREAK.
- BREAK:
  - Stay until rx_s==1 -> IDLE. Prevents a held-low line from producing 0x00 bytes.
- Latency: rx_status rises the clk after the tick at the stop-bit centre, about 9.5 bit times after the start edge plus 2 sync clks.
- rx_data holds its value between bytes; the consumer may sample it at any time after rx_status.
- Back-to-back frames: the next start edge is accepted in the first IDLE clk after STOP, so no idle gap is required.
- Async reset mid-frame:
  - Immediate return to reset values; the partial byte is discarded.
  - After release, a frame already in progress may be mis-framed. It must end in IDLE or BREAK, never in a hang.
- rx_status and frame_err are never both 1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1, with a PARITY state between DATA and STOP, sampled at its bit centre.
  - Even-parity mismatch: at STOP, rx_data is not updated and rx_status is suppressed. frame_err pulses instead, and the stop-bit value then selects IDLE or BREAK as normal.
  - rx_status latency grows by one bit time.
- Undefined: 8N1 as above. No PARITY state; parity logic is absent from the netlist.

Test Plan:
- Nominal byte (CLK_FREQ=1600000, BAUD=10000, so DIV=10 and 160 clk/bit): send 0x55, stop=1 -> rx_data=0x55, rx_status high exactly 1 clk, 1520+/-20 clks after the start edge, frame_err stays 0.
- Glitch rejection: drive rx low for 50 clks, then high -> no rx_status, no frame_err, state back in IDLE; a following 0xA3 is received correctly.
- Framing error: send 0x3C with stop=0, then hold rx low 2000 clks, then high -> one frame_err pulse, rx_data keeps its prior value, no further pulses while low; a subsequent 0x81 gives rx_data=0x81.
- Back-to-back: 0x00 immediately followed by 0xFF with no idle gap -> two rx_status pulses about 1600 clks apart, with values 0x00 then 0xFF.
- Reset mid-frame: assert reset during bit 4 of 0xC7 -> outputs immediately 0x00/0/0; after release and a 2-bit idle, 0x5A is received correctly.
- Parity, with UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> rx_data=0x07 and rx_status. Send 0x07 with parity bit 0 -> frame_err pulse, no rx_status, rx_data unchanged.
